// File: rtl/e203_nice_csr_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e203_nice_csr_resp_pkg : shared CSR indices, STATUS bits, FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package e203_nice_csr_resp_pkg;

    localparam logic [11:0] CSR_CTRL   = 12'hE00;
    localparam logic [11:0] CSR_STATUS = 12'hE01;
    localparam logic [11:0] CSR_ACC    = 12'hE02;
    localparam logic [11:0] CSR_OPND   = 12'hE03;
    localparam logic [11:0] CSR_CYCLE  = 12'hE04;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_LEN_LSB    = 8;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_t;

endpackage
`default_nettype wire

// File: rtl/e203_nice_csr_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e203_nice_csr_engine : accumulate engine (FSM, run counter, ACC)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module e203_nice_csr_engine
    import e203_nice_csr_resp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             acc_wr,
    input  logic [31:0]      acc_wdata,
    input  logic [31:0]      opnd,
    output logic [31:0]      acc,
    output logic             busy,
    output logic             done_pulse
);

    eng_state_t       state;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENG_IDLE;
            cnt        <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            // ACC writes are stalled during RUN, so the two never collide
            if (acc_wr) begin
                acc <= acc_wdata;
            end else if (state == ENG_RUN) begin
                acc <= acc + opnd;
            end

            case (state)
                ENG_IDLE: begin
                    done_pulse <= 1'b0;
                    if (start) begin
                        cnt <= len;
                        if (len != '0) begin
                            state <= ENG_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state      <= ENG_DONE;
                            done_pulse <= 1'b1;
                        end
                    end
                end
                ENG_RUN: begin
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state      <= ENG_DONE;
                        busy       <= 1'b0;
                        done_pulse <= 1'b1;
                    end
                end
                ENG_DONE: begin
                    state      <= ENG_IDLE;
                    done_pulse <= 1'b0;
                end
                default: begin
                    state      <= ENG_IDLE;
                    busy       <= 1'b0;
                    done_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/e203_nice_csr_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e203_nice_csr_resp : NICE CSR responder, CSR bank and engine wrapper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module e203_nice_csr_resp
    import e203_nice_csr_resp_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CYC_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nice_csr_valid,
    output logic        nice_csr_ready,
    input  logic [31:0] nice_csr_addr,
    input  logic        nice_csr_wr,
    input  logic [31:0] nice_csr_wdata,
    output logic [31:0] nice_csr_rdata,
    output logic        eng_busy,
    output logic        eng_done_pulse
);

    logic [11:0]      idx;
    logic             sel_ctrl, sel_status, sel_acc, sel_opnd, sel_cycle;
    logic             mapped, stallable, hs, wr_hs;
    logic [LEN_W-1:0] len;
    logic [31:0]      opnd;
    logic [31:0]      acc;
    logic [CYC_W-1:0] cycle;
    logic [31:0]      cycle_ext;
    logic             st_done, st_err;
    logic             unused_addr_hi;

    assign idx            = nice_csr_addr[11:0];
    assign unused_addr_hi = ^nice_csr_addr[31:12];

    assign sel_ctrl   = (idx == CSR_CTRL);
    assign sel_status = (idx == CSR_STATUS);
    assign sel_acc    = (idx == CSR_ACC);
    assign sel_opnd   = (idx == CSR_OPND);
    assign sel_cycle  = (idx == CSR_CYCLE);
    assign mapped     = sel_ctrl | sel_status | sel_acc | sel_opnd | sel_cycle;
    assign stallable  = sel_ctrl | sel_acc | sel_opnd;

    // ready is a function of registered busy and the address only; valid stays out of its cone
    assign nice_csr_ready = ~(eng_busy & stallable);
    assign hs             = nice_csr_valid & nice_csr_ready;
    assign wr_hs          = hs & nice_csr_wr;

    e203_nice_csr_engine #(
        .LEN_W (LEN_W)
    ) u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (wr_hs & sel_ctrl & nice_csr_wdata[CTRL_START_BIT]),
        .len        (nice_csr_wdata[CTRL_LEN_LSB +: LEN_W]),
        .acc_wr     (wr_hs & sel_acc),
        .acc_wdata  (nice_csr_wdata),
        .opnd       (opnd),
        .acc        (acc),
        .busy       (eng_busy),
        .done_pulse (eng_done_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            opnd    <= '0;
            cycle   <= '0;
            st_done <= 1'b0;
            st_err  <= 1'b0;
        end else begin
            cycle <= cycle + CYC_W'(1);
            if (wr_hs & sel_ctrl) begin
                len <= nice_csr_wdata[CTRL_LEN_LSB +: LEN_W];
            end
            if (wr_hs & sel_opnd) begin
                opnd <= nice_csr_wdata;
            end
            // hardware set takes priority over a same-cycle W1C
            st_done <= eng_done_pulse |
                       (st_done & ~(wr_hs & sel_status & nice_csr_wdata[STATUS_DONE_BIT]));
            st_err  <= (hs & ~mapped) |
                       (st_err & ~(wr_hs & sel_status & nice_csr_wdata[STATUS_ERR_BIT]));
        end
    end

    always_comb begin
        cycle_ext              = '0;
        cycle_ext[CYC_W-1:0]   = cycle;
        nice_csr_rdata         = '0;
        if (nice_csr_valid) begin
            if (sel_ctrl) begin
                nice_csr_rdata[CTRL_LEN_LSB +: LEN_W] = len;
            end else if (sel_status) begin
                nice_csr_rdata[STATUS_BUSY_BIT] = eng_busy;
                nice_csr_rdata[STATUS_DONE_BIT] = st_done;
                nice_csr_rdata[STATUS_ERR_BIT]  = st_err;
            end else if (sel_acc) begin
                nice_csr_rdata = acc;
            end else if (sel_opnd) begin
                nice_csr_rdata = opnd;
            end else if (sel_cycle) begin
                nice_csr_rdata = cycle_ext;
            end
        end
    end

endmodule
`default_nettype wire
